// File: rtl/rf_ctrl_pkg.sv
// Shared types and defaults for the register-file write-port controller.
package rf_ctrl_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [3:0] PC_IDX         = 4'hF;
  localparam int         DEF_DW         = 32;
  localparam int         DEF_AW         = 4;
  localparam int         DEF_NREG       = 15;
  localparam int         DEF_STARVE_MAX = 4;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear address generator: walks r0..NREG-1 and parks on the last one.
module rf_clear_seq
  import rf_ctrl_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int NREG = DEF_NREG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [AW-1:0] clr_cnt,
  output logic          done
);

  assign done = (clr_cnt == AW'(NREG - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt <= '0;
    end else if (en && !done) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write-port owner: clears r0..r14 after reset, then arbitrates
// core writeback (A, priority) against the loader (B, starvation-bounded).
//
// state | meaning
// CLEAR | zeroing r0..NREG-1, one register per cycle; no requests accepted
// RUN   | arbitrating A/B handshakes onto the write port
module rf_write_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int NREG       = DEF_NREG,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic          busy,
  output logic          drop_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [AW-1:0] clr_cnt;
  logic          clr_done;
  logic          force_b;
  logic          a_hs;
  logic          b_hs;
  logic [AW-1:0] xfer_addr;
  logic [DW-1:0] xfer_data;

  rf_clear_seq #(
    .AW   (AW),
    .NREG (NREG)
  ) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .en      (state == CLEAR),
    .clr_cnt (clr_cnt),
    .done    (clr_done)
  );

  // Readies are gated by reset so nothing can be accepted on a reset edge.
  assign force_b  = (state == RUN) && a_valid && b_valid && (starve_cnt == SW'(STARVE_MAX));
  assign a_ready  = !reset && (state == RUN) && !force_b;
  assign b_ready  = !reset && (state == RUN) && (!a_valid || force_b);
  assign busy     = reset || (state == CLEAR);

  assign a_hs      = a_valid && a_ready;
  assign b_hs      = b_valid && b_ready;
  assign xfer_addr = a_hs ? a_addr : b_addr;
  assign xfer_data = a_hs ? a_data : b_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      starve_cnt <= '0;
      we3        <= 1'b0;
      wa3        <= '0;
      wd3        <= '0;
      drop_err   <= 1'b0;
    end else if (state == CLEAR) begin
      we3        <= 1'b1;
      wa3        <= clr_cnt;
      wd3        <= '0;
      drop_err   <= 1'b0;
      starve_cnt <= '0;
      if (clr_done) begin
        state <= RUN;
      end
    end else begin
      if (a_hs || b_hs) begin
        // r15 is the PC: the handshake completes but the write is swallowed.
        if (xfer_addr == AW'(PC_IDX)) begin
          we3      <= 1'b0;
          drop_err <= 1'b1;
        end else begin
          we3      <= 1'b1;
          wa3      <= xfer_addr;
          wd3      <= xfer_data;
          drop_err <= 1'b0;
        end
      end else begin
        we3      <= 1'b0;
        drop_err <= 1'b0;
      end

      if (!b_valid || b_hs) begin
        starve_cnt <= '0;
      end else if (a_valid && (starve_cnt != SW'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule
